// File: rtl/parking_meter.sv
// Parking bay meter: counts rising edges of the divider output as seconds,
// accumulates a per-started-unit fee, and holds the result for billing.
module parking_meter #(
  parameter int unsigned kUnitSec  = 3600,
  parameter int unsigned kRate     = 5,
  parameter int unsigned kFeeMax   = 999,
  parameter int unsigned kBillHold = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        car_in,
  input  logic        car_out,
  input  logic        paid,
  output logic [1:0]  state,
  output logic        occupied,
  output logic        bill_valid,
  output logic [15:0] elapsed,
  output logic [9:0]  fee
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARKED = 2'd1,
    BILL   = 2'd2
  } state_t;

  localparam logic [15:0] kUnitLast = 16'(kUnitSec - 1);
  localparam logic [15:0] kHoldLast = 16'(kBillHold - 1);
  localparam logic [10:0] kRate11   = 11'(kRate);
  localparam logic [10:0] kFeeMax11 = 11'(kFeeMax);

  state_t      r_state, w_state_nx;
  logic        r_tick_d;
  logic [15:0] r_elapsed, w_elapsed_nx;
  logic [15:0] r_unit_cnt, w_unit_nx;
  logic [15:0] r_hold_cnt, w_hold_nx;
  logic [9:0]  r_fee, w_fee_nx;

  logic        w_tick;
  logic [10:0] w_fee_sum;
  logic [9:0]  w_fee_add;
  logic [15:0] w_elapsed_inc;

  assign w_tick        = tick_in & ~r_tick_d;
  // 11-bit sum so the ceiling compare never sees a wrapped value
  assign w_fee_sum     = {1'b0, r_fee} + kRate11;
  assign w_fee_add     = (w_fee_sum > kFeeMax11) ? kFeeMax11[9:0] : w_fee_sum[9:0];
  assign w_elapsed_inc = (r_elapsed == 16'hFFFF) ? r_elapsed : r_elapsed + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tick_d   <= 1'b0;
      r_elapsed  <= '0;
      r_unit_cnt <= '0;
      r_hold_cnt <= '0;
      r_fee      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_tick_d   <= tick_in;
      r_elapsed  <= w_elapsed_nx;
      r_unit_cnt <= w_unit_nx;
      r_hold_cnt <= w_hold_nx;
      r_fee      <= w_fee_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_elapsed_nx = r_elapsed;
    w_unit_nx    = r_unit_cnt;
    w_hold_nx    = r_hold_cnt;
    w_fee_nx     = r_fee;
    case (r_state)
      IDLE: begin
        if (car_in) begin
          w_state_nx   = PARKED;
          w_elapsed_nx = '0;
          w_unit_nx    = '0;
          w_fee_nx     = 10'(kRate);
        end
      end
      PARKED: begin
        // a tick coinciding with car_out is still billed
        if (w_tick) begin
          w_elapsed_nx = w_elapsed_inc;
          if (r_unit_cnt == kUnitLast) begin
            w_unit_nx = '0;
            w_fee_nx  = w_fee_add;
          end else begin
            w_unit_nx = r_unit_cnt + 16'd1;
          end
        end
        if (car_out) begin
          w_state_nx = BILL;
          w_hold_nx  = '0;
        end
      end
      BILL: begin
        if (car_in) begin
          w_state_nx   = PARKED;
          w_elapsed_nx = '0;
          w_unit_nx    = '0;
          w_fee_nx     = 10'(kRate);
        end else if (paid) begin
          w_state_nx = IDLE;
        end else if (w_tick) begin
          if (r_hold_cnt == kHoldLast) begin
            w_state_nx = IDLE;
          end else begin
            w_hold_nx = r_hold_cnt + 16'd1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign state      = r_state;
  assign occupied   = (r_state == PARKED);
  assign bill_valid = (r_state == BILL);
  assign elapsed    = r_elapsed;
  assign fee        = r_fee;

endmodule

// File: doc/parking_meter.md
Name: parking_meter

Overview:
- Downstream consumer of the clock divider's slow output `clk_out`.
- Detects each rising edge of that output inside the 50 MHz `clk` domain and uses it as a one-second tick.
- Times one vehicle's stay in a parking bay and accumulates the fee.
- Presents frozen elapsed time and fee for billing after the vehicle exits; the display and billing logic read these results.

Parameters:
- kUnitSec, 3600: ticks per billing unit; fee is charged per started unit; legal range 1..65535.
- kRate, 5: fee added per started unit; legal range 1..999.
- kFeeMax, 999: fee saturation ceiling.
- kBillHold, 30: ticks spent in BILL before auto-return to IDLE if `paid` never arrives; legal range 1..65535.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  divider output (level; synchronous to clk); each rising edge = one tick.
- car_in  input  1  one-cycle pulse: vehicle entered bay.
- car_out  input  1  one-cycle pulse: vehicle left bay.
- paid  input  1  one-cycle pulse: bill settled.
- state  output  2  0=IDLE, 1=PARKED, 2=BILL; encoding 3 is never produced.
- occupied  output  1  high in PARKED.
- bill_valid  output  1  high in BILL.
- elapsed  output  16  ticks counted in the current or last stay, binary, saturating at 65535.
- fee  output  10  accumulated fee, binary, saturating at kFeeMax.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release):
  - state=IDLE; occupied=0; bill_valid=0; elapsed=0; fee=0.
  - tick_d=0; unit_cnt=0; hold_cnt=0.
- Tick detect:
  - tick_d <= tick_in every edge; tick = tick_in & ~tick_d (combinational).
  - Counters update on the clk edge at which tick_in is first sampled high: one-edge latency.
  - A high tick_in at reset release yields one tick. It is harmless because state is IDLE.
- All outputs are registered. occupied and bill_valid are decoded from the state register.
- IDLE:
  - car_in -> PARKED; same edge: elapsed=0, unit_cnt=0, fee=kRate (first unit charged on entry).
  - car_out, paid and tick are ignored; elapsed and fee hold.
- PARKED, on tick:
  - elapsed += 1, saturating at 65535.
  - unit_cnt += 1. When unit_cnt reaches kUnitSec-1 and a tick arrives, unit_cnt -> 0 and fee += kRate, saturating at kFeeMax.
  - Fee saturation means: if fee+kRate > kFeeMax, fee = kFeeMax.
- PARKED, other events:
  - car_out -> BILL, hold_cnt=0.
  - If tick and car_out occur on the same edge, the tick is applied first (counts and fee include it), then BILL.
  - car_in and paid are ignored.
- BILL:
  - elapsed and fee are frozen.
  - paid -> IDLE; elapsed and fee keep their values until the next car_in.
  - car_in -> PARKED with the entry clear applied (back-to-back vehicle, unpaid bill discarded). car_in takes priority over paid on the same edge.
  - Each tick increments hold_cnt. When hold_cnt reaches kBillHold-1 and a tick arrives -> IDLE (auto-timeout).
  - car_out is ignored.
- Simultaneous car_in and car_out in IDLE: car_in wins (-> PARKED).
- Reset mid-stay: aborts immediately to reset values; no bill is produced.
- Arithmetic:
  - unit_cnt and hold_cnt are 16-bit.
  - The fee adder is 11-bit, compared against kFeeMax before the register is written; no wrap-around anywhere.

Test Plan:
- Reset with rst_n low mid-PARKED (elapsed=7): all outputs 0 and state=IDLE asynchronously, before the next clk edge.
- kUnitSec=4, kRate=5: car_in, then 9 ticks, then car_out -> elapsed=9; fee 5 after 0 ticks, 10 after 4, 15 after 8; state=BILL, bill_valid=1.
- kUnitSec=1, kRate=400, kFeeMax=999: car_in, then 3 ticks -> fee sequence 400, 800, 999, 999; elapsed=3.
- tick rising edge on the same edge as car_out with elapsed=5 -> elapsed=6, state=BILL; a further tick leaves elapsed=6.
- In BILL with kBillHold=3: no paid, 3 ticks -> state=IDLE after the third tick; elapsed and fee retain their bill values. Separate run: paid after 1 tick -> IDLE immediately.
- In BILL, car_in and paid on the same edge -> PARKED, elapsed=0, fee=kRate. In IDLE, car_out alone -> no state change.
